// File: rtl/ysyx_25060173_idu.sv
// ysyx_25060173_idu: addi/ebreak decode stage with a 32x32 register file and a one-entry output register.
// Stops accepting fetches once an ebreak has been consumed downstream; only rst clears that.
module ysyx_25060173_idu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic        alu_op,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen,
    output logic        out_ebreak,
    output logic        out_illegal,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        halted
);
    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] regs [32];
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        is_addi;
    logic        is_ebreak;
    logic [31:0] rs1_val;
    logic        accept;
    logic        consume;

    assign rs1       = in_inst[19:15];
    assign rd        = in_inst[11:7];
    assign is_addi   = in_inst[6:0] == 7'b0010011 && in_inst[14:12] == 3'b000;
    assign is_ebreak = in_inst == 32'h0010_0073;

    // x0 wins over the bypass so a dropped write to x0 never leaks into a read
    assign rs1_val = rs1 == 5'd0 ? 32'd0
                   : (wb_en && wb_addr == rs1) ? wb_data
                   : regs[rs1];

    assign halted   = state == HALT;
    assign in_ready = !halted && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            out_valid   <= 1'b0;
            out_pc      <= RESET_PC;
            alu_src1    <= 32'd0;
            alu_src2    <= 32'd0;
            alu_op      <= 1'b0;
            out_rd      <= 5'd0;
            out_rd_wen  <= 1'b0;
            out_ebreak  <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (accept) begin
                out_pc      <= in_pc;
                alu_src1    <= rs1_val;
                alu_src2    <= {{20{in_inst[31]}}, in_inst[31:20]};
                alu_op      <= is_addi;
                out_rd      <= rd;
                out_rd_wen  <= is_addi && rd != 5'd0;
                out_ebreak  <= is_ebreak;
                out_illegal <= !is_addi && !is_ebreak;
            end
            if (state == HALT) begin
                out_valid <= 1'b0;
            end else if (consume && out_ebreak) begin
                state     <= HALT;
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25060173_idu.sv
// tb_ysyx_25060173_idu: directed vectors with hand-computed expectations for the decode stage.
module tb_ysyx_25060173_idu;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        alu_op;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_ebreak;
    logic        out_illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;

    int pass_cnt = 0;
    int total_cnt = 0;

    ysyx_25060173_idu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_ebreak(out_ebreak), .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = 32'd0; in_inst = 32'd0;
        out_ready = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_out_pc", out_pc, 32'h8000_0000);
        check("rst_src1", alu_src1, 32'd0);
        check("rst_src2", alu_src2, 32'd0);
        check("rst_flags", {27'd0, alu_op, out_rd_wen, out_ebreak, out_illegal, 1'b0}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // addi x1,x0,5
        feed(32'h8000_0000, 32'h0050_0093);
        step();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_pc", out_pc, 32'h8000_0000);
        check("t1_src1", alu_src1, 32'd0);
        check("t1_src2", alu_src2, 32'd5);
        check("t1_op", {31'd0, alu_op}, 32'd1);
        check("t1_rd", {27'd0, out_rd}, 32'd1);
        check("t1_rd_wen", {31'd0, out_rd_wen}, 32'd1);
        check("t1_illegal", {31'd0, out_illegal}, 32'd0);

        // addi x3,x2,-1 accepted back-to-back while writing x2=0x10 (bypass)
        check("t2_ready", {31'd0, in_ready}, 32'd1);
        feed(32'h8000_0004, 32'hFFF1_0193);
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0010;
        step();
        wb_en = 1'b0;
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_pc", out_pc, 32'h8000_0004);
        check("t2_src1_bypass", alu_src1, 32'h0000_0010);
        check("t2_src2", alu_src2, 32'hFFFF_FFFF);
        check("t2_rd", {27'd0, out_rd}, 32'd3);

        // addi x4,x2,0 reads the stored x2
        feed(32'h8000_0008, 32'h0001_0213);
        step();
        check("t3_src1_stored", alu_src1, 32'h0000_0010);
        check("t3_src2", alu_src2, 32'd0);
        check("t3_rd", {27'd0, out_rd}, 32'd4);

        // back-pressure with a write to x2 that must not refresh the held src1
        out_ready = 1'b0;
        feed(32'h8000_000C, 32'h0010_0293);
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0099;
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            wb_en = 1'b0;
            check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_pc", out_pc, 32'h8000_0008);
            check("bp_src1", alu_src1, 32'h0000_0010);
            check("bp_rd", {27'd0, out_rd}, 32'd4);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_next_pc", out_pc, 32'h8000_000C);
        check("bp_next_rd", {27'd0, out_rd}, 32'd5);
        check("bp_next_src2", alu_src2, 32'd1);

        // addi x0,x0,7 must not request writeback
        feed(32'h8000_0010, 32'h0070_0013);
        step();
        check("x0_rd_wen", {31'd0, out_rd_wen}, 32'd0);
        check("x0_op", {31'd0, alu_op}, 32'd1);
        check("x0_src2", alu_src2, 32'd7);

        // write to x0 dropped; read x0 while writing it still gives 0
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        feed(32'h8000_0014, 32'h0000_0313);
        step();
        wb_en = 1'b0;
        check("x0_read", alu_src1, 32'd0);
        check("x0_read_rd", {27'd0, out_rd}, 32'd6);

        // x2 now holds 0x99 from the stalled write
        feed(32'h8000_0018, 32'h0001_0393);
        step();
        check("x2_after_stall_write", alu_src1, 32'h0000_0099);

        // unsupported words
        feed(32'h8000_001C, 32'h0000_0033);
        step();
        check("ill_flag", {31'd0, out_illegal}, 32'd1);
        check("ill_op", {31'd0, alu_op}, 32'd0);
        check("ill_rd_wen", {31'd0, out_rd_wen}, 32'd0);
        feed(32'h8000_0020, 32'h0000_1093);
        step();
        check("ill_slli_flag", {31'd0, out_illegal}, 32'd1);
        check("ill_slli_rd_wen", {31'd0, out_rd_wen}, 32'd0);
        check("ill_no_halt", {31'd0, halted}, 32'd0);
        check("ill_ready", {31'd0, in_ready}, 32'd1);

        // ebreak
        feed(32'h8000_0024, 32'h0010_0073);
        step();
        in_valid = 1'b0;
        check("eb_flag", {31'd0, out_ebreak}, 32'd1);
        check("eb_op", {31'd0, alu_op}, 32'd0);
        check("eb_illegal", {31'd0, out_illegal}, 32'd0);
        check("eb_not_yet_halted", {31'd0, halted}, 32'd0);
        step();
        check("eb_halted", {31'd0, halted}, 32'd1);
        check("eb_in_ready", {31'd0, in_ready}, 32'd0);
        check("eb_out_valid", {31'd0, out_valid}, 32'd0);
        feed(32'h8000_0028, 32'h0050_0093);
        for (int k = 0; k < 3; k++) begin
            step();
            check("halt_in_ready", {31'd0, in_ready}, 32'd0);
            check("halt_out_valid", {31'd0, out_valid}, 32'd0);
            check("halt_sticky", {31'd0, halted}, 32'd1);
        end
        in_valid = 1'b0;

        // async reset clears halt and the register file
        #2 rst = 1'b1;
        #1;
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_out_pc", out_pc, 32'h8000_0000);
        check("rst2_ebreak", {31'd0, out_ebreak}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        feed(32'h8000_0000, 32'h0001_0393);
        step();
        check("rst2_valid", {31'd0, out_valid}, 32'd1);
        check("rst2_x2_cleared", alu_src1, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
